prgrom_loader: RTL and testbench
================================

# prgrom_loader

Program instruction memory with an integrated serial boot loader. It sits directly upstream of the fetch stage: in run mode it returns the instruction word addressed by the fetch PC; in load mode it holds the CPU and assembles incoming UART bytes into 32-bit words written sequentially from word 0. Leaving load mode releases the CPU, which restarts from PC 0 via `cpu_hold`.

## Interface
Parameters:
- `ADDR_W`, default 14, word-address width; memory depth is 2^ADDR_W words (64 KiB at the default).

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- `prog_mode`  in  1  level; 1 requests load mode, 0 requests run mode.
- `rx_data`  in  8  received byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `fetch_addr`  in  32  byte address from the fetch-stage PC; bits [ADDR_W+1:2] select the word, bits [1:0] are ignored.
- `Instruction`  out  32  registered read data to the fetch stage.
- `cpu_hold`  out  1  1 while loading; drives the fetch stage's active-high reset.
- `load_done`  out  1  one-cycle pulse when a load session ends.
- `load_err`  out  1  sticky error flag for the last session: overflow or partial word.
- `word_count`  out  ADDR_W+1  number of words written in the current or last session.

## Operation
- States: RUN and LOAD. Reset enters RUN.
- RUN:
  - `cpu_hold`=0.
  - Each cycle, `Instruction` <= mem[`fetch_addr`[ADDR_W+1:2]].
  - `rx_valid` is ignored.
  - When `prog_mode`=1 is sampled: go to LOAD; clear `byte_cnt`, `wr_addr`, `word_count` and `load_err`.
- LOAD:
  - `cpu_hold`=1 and `Instruction` is forced to 0 (NOP).
  - On `rx_valid`, shift the byte into the assembly register, big-endian: the first byte lands in [31:24], the fourth in [7:0]. Increment `byte_cnt` modulo 4.
  - On the fourth byte, write mem[`wr_addr`] with the assembled word and increment `wr_addr` and `word_count`.
  - Overflow: once `word_count` = 2^ADDR_W, further bytes are discarded, no write occurs, `wr_addr` does not wrap, and `load_err` is set.
- LOAD to RUN, when `prog_mode`=0 is sampled:
  - Pulse `load_done` for one cycle.
  - If `byte_cnt`≠0, the partial word is discarded (never written) and `load_err` is set.
  - `word_count` and `load_err` hold until the next session.
- Simultaneous events:
  - `rx_valid` in the same cycle as `prog_mode` falling: the byte is accepted first, and the partial-word check uses the updated `byte_cnt`.
  - `prog_mode` rising with `rx_valid` in RUN: the byte is dropped.
- Reset mid-load: state returns to RUN and all counters, flags and `Instruction` clear. Memory contents are not cleared; words already written remain. Reset never alters memory.
- Memory may be initialised at elaboration from a hex image. Power-up contents are otherwise undefined.

## Timing
- Reset values: `Instruction`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0, `word_count`=0.
- Fetch read latency is 1 cycle. The address presented before edge N appears on `Instruction` after edge N. The fetch stage updates PC on the falling edge, so data is ready before the next falling edge.
- `cpu_hold` rises on the edge that samples `prog_mode`=1. It falls on the edge that samples `prog_mode`=0, the same edge that raises `load_done`.
- A memory write occurs on the edge sampling the fourth `rx_valid`. The word is readable through the fetch port from the next edge onward.
- There is no back-pressure: a byte arrives at most once per cycle and every strobe is consumed or dropped in that cycle.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `prog_mode`=0 -> all outputs 0 and state RUN.
- Basic load:
  - Stimulus: `prog_mode`=1, then bytes 24 08 00 05 00 00 00 0C, then `prog_mode`=0.
  - Response: `word_count`=2, one-cycle `load_done`, `load_err`=0.
  - Readback: `fetch_addr`=0x0 gives `Instruction`=0x24080005 next cycle; 0x4 gives 0x0000000C; 0x7 also gives 0x0000000C.
- Partial word: 6 bytes then `prog_mode`=0 -> `word_count`=1, `load_err`=1, mem[1] unchanged from its prior value.
- Overflow, with `ADDR_W`=2: 20 bytes -> `word_count`=4, `load_err`=1, mem[0] still holds the first word (no wrap).
- Reset mid-load: after 3 bytes into a session that already wrote 1 word, assert `reset`=0 -> `cpu_hold`=0, `word_count`=0, `load_err`=0, mem[0] retained and readable.
- Coincident end: the 4th byte's `rx_valid` in the same cycle as `prog_mode` falling -> word written, `word_count` incremented, `load_err`=0, `load_done` pulses once.

Source files
------------

// File: rtl/prgrom_loader.sv
// Instruction ROM/RAM feeding the fetch stage, with a UART boot loader that assembles
// big-endian bytes into words written sequentially from word 0 while the CPU is held.
module prgrom_loader #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       Instruction,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StLoad = 1'b1;

  logic [31:0]       mem [Depth];

  logic [0:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              load_err_q, load_err_d;
  logic              load_done_q, load_done_d;
  logic [31:0]       instr_q;
  logic              mem_we;
  logic              full;
  logic [ADDR_W-1:0] rd_idx;
  logic              unused_addr;

  assign rd_idx      = fetch_addr[ADDR_W+1:2];
  assign unused_addr = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};
  // word_count reaching Depth sets its MSB; from then on bytes are dropped.
  assign full        = word_count_q[ADDR_W];

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    load_err_d   = load_err_q;
    load_done_d  = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      StRun: begin
        if (prog_mode) begin
          state_d      = StLoad;
          byte_cnt_d   = '0;
          wr_addr_d    = '0;
          word_count_d = '0;
          load_err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (rx_valid) begin
          if (full) begin
            load_err_d = 1'b1;
          end else begin
            asm_d      = {asm_q[15:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we       = 1'b1;
              wr_addr_d    = wr_addr_q + ADDR_W'(1);
              word_count_d = word_count_q + (ADDR_W+1)'(1);
            end
          end
        end
        // A byte arriving with the exit is counted before the partial-word check.
        if (!prog_mode) begin
          state_d     = StRun;
          load_done_d = 1'b1;
          if (byte_cnt_d != 2'd0) load_err_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StRun;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      load_err_q   <= 1'b0;
      load_done_q  <= 1'b0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      load_err_q   <= load_err_d;
      load_done_q  <= load_done_d;
      instr_q      <= (state_d == StRun) ? mem[rd_idx] : '0;
    end
  end

  // Memory has no reset; a reset cycle suppresses any pending write.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem[wr_addr_q] <= {asm_q, rx_data};
  end

  assign Instruction = instr_q;
  assign cpu_hold    = (state_q == StLoad);
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_prgrom_loader.sv
// Randomized bench for prgrom_loader: sessions of bytes are checked against a
// session-level model of the expected word count, error flag and memory image.
module tb_prgrom_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  typedef logic [7:0] byte_q_t[$];

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          prog_mode = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [31:0]   fetch_addr = 32'h0;
  logic [31:0]   Instruction;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   mm [DEPTH];
  bit            mv [DEPTH];

  prgrom_loader #(.ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .prog_mode   (prog_mode),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .fetch_addr  (fetch_addr),
    .Instruction (Instruction),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .word_count  (word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_addr(input string tag, input logic [31:0] a, input logic [31:0] exp);
    fetch_addr = a;
    rx_valid   = 1'($urandom_range(0, 1));  // strobes in run mode must be ignored
    rx_data    = 8'($urandom);
    @(negedge clock);
    rx_valid = 1'b0;
    check(tag, Instruction, exp);
  endtask

  task automatic read_all();
    logic [31:0] a;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mv[i]) begin
        a = $urandom;
        a[AW+1:2] = i[AW-1:0];
        read_addr("readback", a, mm[i]);
      end
    end
  endtask

  task automatic run_session(input byte_q_t bytes, input bit coincident);
    int n;
    int nw;
    bit err;
    bit last;
    n = bytes.size();
    prog_mode = 1'b1;
    rx_valid  = 1'($urandom_range(0, 1));  // dropped on the entry edge
    rx_data   = 8'($urandom);
    @(negedge clock);
    rx_valid = 1'b0;
    check("hold_on", {31'b0, cpu_hold}, 32'd1);
    check("nop_in_load", Instruction, 32'h0);
    check("wc_cleared", {29'b0, word_count}, 32'd0);
    for (int i = 0; i < n; i++) begin
      last       = coincident && (i == n - 1);
      rx_data    = bytes[i];
      rx_valid   = 1'b1;
      fetch_addr = $urandom;
      if (last) prog_mode = 1'b0;
      @(negedge clock);
      rx_valid = 1'b0;
      if (!last) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    if (!(coincident && n > 0)) begin
      prog_mode = 1'b0;
      @(negedge clock);
    end
    nw  = (n / 4 > int'(DEPTH)) ? int'(DEPTH) : n / 4;
    err = (n > 4 * int'(DEPTH)) || (n % 4 != 0);
    for (int w = 0; w < nw; w++) begin
      mm[w] = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
      mv[w] = 1'b1;
    end
    check("load_done", {31'b0, load_done}, 32'd1);
    check("hold_off", {31'b0, cpu_hold}, 32'd0);
    check("word_count", {29'b0, word_count}, nw);
    check("load_err", {31'b0, load_err}, {31'b0, err});
    @(negedge clock);
    check("done_one_cycle", {31'b0, load_done}, 32'd0);
    check("wc_holds", {29'b0, word_count}, nw);
    check("err_holds", {31'b0, load_err}, {31'b0, err});
  endtask

  initial begin
    byte_q_t b;
    bit coin;
    int n;
    logic [31:0] w0;

    // Reset
    repeat (2) @(negedge clock);
    check("rst_instr", Instruction, 32'h0);
    check("rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_err", {31'b0, load_err}, 32'd0);
    check("rst_wc", {29'b0, word_count}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Basic load and readback with ignored low address bits
    b = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    run_session(b, 1'b0);
    read_addr("basic_w0", 32'h0, 32'h24080005);
    read_addr("basic_w1", 32'h4, 32'h0000000C);
    read_addr("basic_w1_lsb", 32'h7, 32'h0000000C);

    // Partial word: mem[1] keeps its previous contents
    b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    run_session(b, 1'b0);
    read_addr("partial_w0", 32'h0, 32'hA1B2C3D4);
    read_addr("partial_w1", 32'h4, 32'h0000000C);

    // Overflow: 20 bytes into a 4-word memory, no wrap
    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'(8'h10 + i));
    run_session(b, 1'b0);
    read_addr("ovf_w0", 32'h0, 32'h10111213);
    read_all();

    // Coincident end: fourth byte together with prog_mode falling
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(b, 1'b1);
    read_addr("coin_w0", 32'h0, 32'hDEADBEEF);

    // Reset mid-load after one word and three bytes
    w0 = $urandom;
    prog_mode = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      rx_data  = (i < 4) ? w0[31-8*i -: 8] : 8'($urandom);
      rx_valid = 1'b1;
      @(negedge clock);
    end
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("mid_rst_wc", {29'b0, word_count}, 32'd0);
    check("mid_rst_err", {31'b0, load_err}, 32'd0);
    check("mid_rst_instr", Instruction, 32'h0);
    check("mid_rst_done", {31'b0, load_done}, 32'd0);
    reset = 1'b1;
    prog_mode = 1'b0;
    @(negedge clock);
    mm[0] = w0;
    mv[0] = 1'b1;
    read_addr("mid_rst_w0", 32'h0, w0);
    read_all();

    // Random sessions
    repeat (30) begin
      n = $urandom_range(0, 22);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      coin = (n > 0) && ($urandom_range(0, 3) == 0);
      run_session(b, coin);
      read_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
